nn_data_path: RTL and testbench

Neural-network training datapath: four storages (weights, inputs, labels, 12-bit microcode), a program counter and matrix locator, and an output "dense register" that feeds the downstream dense/activation unit. Each executing cycle fetches the current instruction and reads one weight/input/label row at the locator position. It then latches the decoded fields and data into the dense register. The host writes the storages directly; weight rows can also be updated in place by gradient subtraction.

---
 rtl/nn_data_path.sv | 214 +++++++++++++++++++++
 tb/tb_nn_data_path.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_data_path.sv
// Training datapath: weight/input/label/microcode storages, pc + matrix locator,
// and a dense register capturing one decoded row per execute cycle.
module nn_data_path #(
  parameter int unsigned LAYERS     = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned CODE_DEPTH = 64
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,

  input  logic [47:0] weight_storage_write_interface_write_data,
  input  logic [31:0] weight_storage_write_interface_write_layer_index,
  input  logic [31:0] weight_storage_write_interface_write_row_index,
  input  logic        weight_storage_is_write_interface_is_write,

  input  logic [47:0] weight_storage_update_weight_interface_dc_dw,
  input  logic [31:0] weight_storage_update_weight_interface_layer_index,
  input  logic [31:0] weight_storage_update_weight_interface_row_index,
  input  logic        weight_storage_is_update_interface_is_update,

  input  logic [47:0] input_storage_write_interface_write_data,
  input  logic [31:0] input_storage_write_interface_write_layer_index,
  input  logic [31:0] input_storage_write_interface_write_row_index,
  input  logic        input_storage_is_write_interface_is_write,

  input  logic [47:0] label_storage_write_interface_write_data,
  input  logic [31:0] label_storage_write_interface_write_layer_index,
  input  logic [31:0] label_storage_write_interface_write_row_index,
  input  logic        label_storage_is_write_interface_is_write,

  input  logic [31:0] code_storage_write_interface_write_line,
  input  logic [11:0] code_storage_write_interface_write_data,
  input  logic        code_storage_write_interface_is_write,

  input  logic        code_storage_enable_interface_enable,
  input  logic        controller_enable_interface_enable,
  input  logic        matrix_storage_locator_reset_interface_reset,

  output logic        controller_use_z_interface_use_z,

  output logic [3:0]  decode_to_dense_register_0_out_dense_type_interface_dense_type_out,
  output logic [3:0]  decode_to_dense_register_0_out_forward_interface_act_type_out,
  output logic [7:0]  decode_to_dense_register_0_out_forward_interface_cost_type_out,
  output logic [31:0] decode_to_dense_register_0_out_forward_interface_w_layer_index_out,
  output logic [31:0] decode_to_dense_register_0_out_forward_interface_w_row_index_out,
  output logic        decode_to_dense_register_0_out_forward_interface_backprop_cost_out,
  output logic        decode_to_dense_register_0_out_forward_interface_is_update_out,
  output logic        decode_to_dense_register_0_out_load_w_interface_load_w_out,
  output logic [47:0] decode_to_dense_register_0_out_forward_interface_label_out,
  output logic [47:0] decode_to_dense_register_0_out_weight_interface_w_out,
  output logic [47:0] decode_to_dense_register_0_out_input_interface_x_out
);

  localparam int unsigned LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (CODE_DEPTH > 1) ? $clog2(CODE_DEPTH) : 1;
  localparam logic [LW-1:0] LastLayer = LW'(LAYERS - 1);
  localparam logic [RW-1:0] LastRow   = RW'(ROWS - 1);
  localparam logic [PW-1:0] LastLine  = PW'(CODE_DEPTH - 1);

  logic [47:0] r_weight [LAYERS][ROWS];
  logic [47:0] r_input  [LAYERS][ROWS];
  logic [47:0] r_label  [LAYERS][ROWS];
  logic [11:0] r_code   [CODE_DEPTH];

  logic [LW-1:0] r_layer;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_pc;

  logic [3:0]  r_dense_type;
  logic [3:0]  r_act_type;
  logic [7:0]  r_cost_type;
  logic [31:0] r_w_layer;
  logic [31:0] r_w_row;
  logic        r_backprop;
  logic        r_is_update;
  logic        r_load_w;
  logic [47:0] r_label_out;
  logic [47:0] r_w_out;
  logic [47:0] r_x_out;

  logic [11:0] w_ir;
  logic        w_exec;

  // Three independent 16-bit lanes, each wrapping on its own.
  function automatic logic [47:0] lane_sub(input logic [47:0] a, input logic [47:0] b);
    lane_sub = {a[47:32] - b[47:32], a[31:16] - b[31:16], a[15:0] - b[15:0]};
  endfunction

  // Matrix storages; out-of-range indices simply match no entry.
  for (genvar gl = 0; gl < LAYERS; gl++) begin : g_layer
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      logic w_wgt_wr, w_wgt_upd, w_in_wr, w_lab_wr;

      assign w_wgt_wr = weight_storage_is_write_interface_is_write &&
                        weight_storage_write_interface_write_layer_index == 32'(gl) &&
                        weight_storage_write_interface_write_row_index == 32'(gr);
      assign w_wgt_upd = weight_storage_is_update_interface_is_update &&
                         weight_storage_update_weight_interface_layer_index == 32'(gl) &&
                         weight_storage_update_weight_interface_row_index == 32'(gr);
      assign w_in_wr = input_storage_is_write_interface_is_write &&
                       input_storage_write_interface_write_layer_index == 32'(gl) &&
                       input_storage_write_interface_write_row_index == 32'(gr);
      assign w_lab_wr = label_storage_is_write_interface_is_write &&
                        label_storage_write_interface_write_layer_index == 32'(gl) &&
                        label_storage_write_interface_write_row_index == 32'(gr);

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_weight[gl][gr] <= '0;
        end else if (w_wgt_wr) begin
          r_weight[gl][gr] <= weight_storage_write_interface_write_data;
        end else if (w_wgt_upd) begin
          r_weight[gl][gr] <= lane_sub(r_weight[gl][gr],
                                       weight_storage_update_weight_interface_dc_dw);
        end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_input[gl][gr] <= '0;
        end else if (w_in_wr) begin
          r_input[gl][gr] <= input_storage_write_interface_write_data;
        end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_label[gl][gr] <= '0;
        end else if (w_lab_wr) begin
          r_label[gl][gr] <= label_storage_write_interface_write_data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < CODE_DEPTH; gi++) begin : g_code
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_code[gi] <= '0;
      end else if (code_storage_write_interface_is_write &&
                   code_storage_write_interface_write_line == 32'(gi)) begin
        r_code[gi] <= code_storage_write_interface_write_data;
      end
    end
  end

  assign w_ir   = code_storage_enable_interface_enable ? r_code[r_pc] : 12'h000;
  assign w_exec = controller_enable_interface_enable && (w_ir[11:8] != 4'd0);

  assign controller_use_z_interface_use_z = w_exec & w_ir[0];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_layer <= '0;
      r_row   <= '0;
      r_pc    <= '0;
    end else if (matrix_storage_locator_reset_interface_reset) begin
      r_layer <= '0;
      r_row   <= '0;
      r_pc    <= '0;
    end else if (w_exec) begin
      if (r_row == LastRow) begin
        r_row   <= '0;
        r_layer <= (r_layer == LastLayer) ? '0 : r_layer + LW'(1);
        r_pc    <= (r_pc == LastLine) ? '0 : r_pc + PW'(1);
      end else begin
        r_row <= r_row + RW'(1);
      end
    end
  end

  // Capture still happens when the locator reset coincides with an execute.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dense_type <= '0;
      r_act_type   <= '0;
      r_cost_type  <= '0;
      r_w_layer    <= '0;
      r_w_row      <= '0;
      r_backprop   <= 1'b0;
      r_is_update  <= 1'b0;
      r_load_w     <= 1'b0;
      r_label_out  <= '0;
      r_w_out      <= '0;
      r_x_out      <= '0;
    end else if (w_exec) begin
      r_dense_type <= w_ir[11:8];
      r_act_type   <= {2'b00, w_ir[7:6]};
      r_cost_type  <= {6'b000000, w_ir[5:4]};
      r_w_layer    <= 32'(r_layer);
      r_w_row      <= 32'(r_row);
      r_backprop   <= w_ir[3];
      r_is_update  <= w_ir[2];
      r_load_w     <= w_ir[1];
      r_label_out  <= r_label[r_layer][r_row];
      r_w_out      <= r_weight[r_layer][r_row];
      r_x_out      <= r_input[r_layer][r_row];
    end
  end

  assign decode_to_dense_register_0_out_dense_type_interface_dense_type_out = r_dense_type;
  assign decode_to_dense_register_0_out_forward_interface_act_type_out      = r_act_type;
  assign decode_to_dense_register_0_out_forward_interface_cost_type_out     = r_cost_type;
  assign decode_to_dense_register_0_out_forward_interface_w_layer_index_out = r_w_layer;
  assign decode_to_dense_register_0_out_forward_interface_w_row_index_out   = r_w_row;
  assign decode_to_dense_register_0_out_forward_interface_backprop_cost_out = r_backprop;
  assign decode_to_dense_register_0_out_forward_interface_is_update_out     = r_is_update;
  assign decode_to_dense_register_0_out_load_w_interface_load_w_out         = r_load_w;
  assign decode_to_dense_register_0_out_forward_interface_label_out         = r_label_out;
  assign decode_to_dense_register_0_out_weight_interface_w_out              = r_w_out;
  assign decode_to_dense_register_0_out_input_interface_x_out               = r_x_out;

endmodule

// File: tb/tb_nn_data_path.sv
// Bench for nn_data_path: directed scenarios plus random traffic, all checked each cycle
// against a behavioural storage/locator model.
module tb_nn_data_path;
  localparam int NL = 4;
  localparam int NR = 4;
  localparam int CD = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [47:0] ww_d, wu_d, xi_d, lb_d;
  logic [31:0] ww_l, ww_r, wu_l, wu_r, xi_l, xi_r, lb_l, lb_r, cw_line;
  logic        ww_en, wu_en, xi_en, lb_en, cw_en;
  logic [11:0] cw_data;
  logic        code_en, ctrl_en, loc_rst;

  logic        uz;
  logic [3:0]  o_dt, o_act;
  logic [7:0]  o_cost;
  logic [31:0] o_wl, o_wr;
  logic        o_bp, o_iu, o_lw;
  logic [47:0] o_lab, o_w, o_x;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  // Behavioural model state
  logic [47:0] m_w [NL][NR];
  logic [47:0] m_x [NL][NR];
  logic [47:0] m_lb[NL][NR];
  logic [11:0] m_code[CD];
  int          m_l, m_r, m_pc;
  logic [3:0]  e_dt, e_act;
  logic [7:0]  e_cost;
  logic [31:0] e_wl, e_wr;
  logic        e_bp, e_iu, e_lw;
  logic [47:0] e_lab, e_w, e_x;

  nn_data_path #(.LAYERS(NL), .ROWS(NR), .CODE_DEPTH(CD)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .weight_storage_write_interface_write_data(ww_d),
    .weight_storage_write_interface_write_layer_index(ww_l),
    .weight_storage_write_interface_write_row_index(ww_r),
    .weight_storage_is_write_interface_is_write(ww_en),
    .weight_storage_update_weight_interface_dc_dw(wu_d),
    .weight_storage_update_weight_interface_layer_index(wu_l),
    .weight_storage_update_weight_interface_row_index(wu_r),
    .weight_storage_is_update_interface_is_update(wu_en),
    .input_storage_write_interface_write_data(xi_d),
    .input_storage_write_interface_write_layer_index(xi_l),
    .input_storage_write_interface_write_row_index(xi_r),
    .input_storage_is_write_interface_is_write(xi_en),
    .label_storage_write_interface_write_data(lb_d),
    .label_storage_write_interface_write_layer_index(lb_l),
    .label_storage_write_interface_write_row_index(lb_r),
    .label_storage_is_write_interface_is_write(lb_en),
    .code_storage_write_interface_write_line(cw_line),
    .code_storage_write_interface_write_data(cw_data),
    .code_storage_write_interface_is_write(cw_en),
    .code_storage_enable_interface_enable(code_en),
    .controller_enable_interface_enable(ctrl_en),
    .matrix_storage_locator_reset_interface_reset(loc_rst),
    .controller_use_z_interface_use_z(uz),
    .decode_to_dense_register_0_out_dense_type_interface_dense_type_out(o_dt),
    .decode_to_dense_register_0_out_forward_interface_act_type_out(o_act),
    .decode_to_dense_register_0_out_forward_interface_cost_type_out(o_cost),
    .decode_to_dense_register_0_out_forward_interface_w_layer_index_out(o_wl),
    .decode_to_dense_register_0_out_forward_interface_w_row_index_out(o_wr),
    .decode_to_dense_register_0_out_forward_interface_backprop_cost_out(o_bp),
    .decode_to_dense_register_0_out_forward_interface_is_update_out(o_iu),
    .decode_to_dense_register_0_out_load_w_interface_load_w_out(o_lw),
    .decode_to_dense_register_0_out_forward_interface_label_out(o_lab),
    .decode_to_dense_register_0_out_weight_interface_w_out(o_w),
    .decode_to_dense_register_0_out_input_interface_x_out(o_x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [47:0] sub3(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] res;
    logic [15:0] t;
    for (int k = 0; k < 3; k++) begin
      t = a[k*16 +: 16] - b[k*16 +: 16];
      res[k*16 +: 16] = t;
    end
    return res;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Reference model: one step per rising edge, reads before writes.
  initial begin
    logic [11:0] ir;
    bit          ex;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int l = 0; l < NL; l++)
          for (int r = 0; r < NR; r++) begin
            m_w[l][r] = '0; m_x[l][r] = '0; m_lb[l][r] = '0;
          end
        for (int i = 0; i < CD; i++) m_code[i] = '0;
        m_l = 0; m_r = 0; m_pc = 0;
        e_dt = '0; e_act = '0; e_cost = '0; e_wl = '0; e_wr = '0;
        e_bp = 0; e_iu = 0; e_lw = 0; e_lab = '0; e_w = '0; e_x = '0;
      end else begin
        ir = code_en ? m_code[m_pc] : 12'h000;
        ex = ctrl_en && (ir[11:8] != 0);
        if (ex) begin
          e_dt = ir[11:8]; e_act = 4'(ir[7:6]); e_cost = 8'(ir[5:4]);
          e_bp = ir[3]; e_iu = ir[2]; e_lw = ir[1];
          e_wl = m_l; e_wr = m_r;
          e_w = m_w[m_l][m_r]; e_x = m_x[m_l][m_r]; e_lab = m_lb[m_l][m_r];
        end
        if (loc_rst) begin
          m_l = 0; m_r = 0; m_pc = 0;
        end else if (ex) begin
          m_r++;
          if (m_r == NR) begin
            m_r = 0;
            m_l = (m_l + 1) % NL;
            m_pc = (m_pc + 1) % CD;
          end
        end
        if (wu_en && wu_l < NL && wu_r < NR) m_w[wu_l][wu_r] = sub3(m_w[wu_l][wu_r], wu_d);
        if (ww_en && ww_l < NL && ww_r < NR) m_w[ww_l][ww_r] = ww_d;
        if (xi_en && xi_l < NL && xi_r < NR) m_x[xi_l][xi_r] = xi_d;
        if (lb_en && lb_l < NL && lb_r < NR) m_lb[lb_l][lb_r] = lb_d;
        if (cw_en && cw_line < CD) m_code[cw_line] = cw_data;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [11:0] ir;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        ir = code_en ? m_code[m_pc] : 12'h000;
        chk("use_z", uz, ctrl_en && ir[11:8] != 0 && ir[0]);
        chk("dense_type", o_dt, e_dt);
        chk("act_type", o_act, e_act);
        chk("cost_type", o_cost, e_cost);
        chk("w_layer", o_wl, e_wl);
        chk("w_row", o_wr, e_wr);
        chk("backprop", o_bp, e_bp);
        chk("is_update", o_iu, e_iu);
        chk("load_w", o_lw, e_lw);
        chk("label", o_lab, e_lab);
        chk("w_out", o_w, e_w);
        chk("x_out", o_x, e_x);
      end
    end
  end

  task automatic idle();
    ww_en = 0; wu_en = 0; xi_en = 0; lb_en = 0; cw_en = 0; loc_rst = 0;
  endtask

  task automatic wr_weight(input int l, input int r, input logic [47:0] d);
    ww_en = 1; ww_l = l; ww_r = r; ww_d = d;
    @(negedge clk);
    ww_en = 0;
  endtask

  task automatic upd_weight(input int l, input int r, input logic [47:0] d);
    wu_en = 1; wu_l = l; wu_r = r; wu_d = d;
    @(negedge clk);
    wu_en = 0;
  endtask

  task automatic wr_code(input int line, input logic [11:0] d);
    cw_en = 1; cw_line = line; cw_data = d;
    @(negedge clk);
    cw_en = 0;
  endtask

  initial begin
    ww_d = '0; wu_d = '0; xi_d = '0; lb_d = '0;
    ww_l = '0; ww_r = '0; wu_l = '0; wu_r = '0; xi_l = '0; xi_r = '0; lb_l = '0; lb_r = '0;
    cw_line = '0; cw_data = '0;
    idle();
    code_en = 1; ctrl_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1; cmp_en = 1;
    @(posedge clk); #1;
    chk("rst_dense_type", o_dt, 4'd0);
    chk("rst_use_z", uz, 1'b0);
    chk("rst_w_out", o_w, 48'd0);

    // Program one instruction and run its four rows
    @(negedge clk);
    ctrl_en = 0;
    for (int r = 0; r < NR; r++) wr_weight(0, r, {3{16'(r)}});
    wr_code(0, 12'h1CB);
    ctrl_en = 1;
    for (int r = 0; r < NR; r++) begin
      @(posedge clk); #1;
      chk("run_row", o_wr, 32'(r));
      chk("run_w", o_w, {3{16'(r)}});
      chk("run_act", o_act, 4'd3);
      chk("run_load_w", o_lw, 1'b1);
    end
    chk("halt_use_z", uz, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("halt_hold_row", o_wr, 32'd3);
    chk("halt_hold_w", o_w, 48'h0003_0003_0003);

    // Gradient update, read back through execution at L=1
    @(negedge clk);
    ctrl_en = 0;
    wr_weight(1, 2, 48'h0005_0005_0005);
    upd_weight(1, 2, 48'h0006_0001_0000);
    wr_code(1, 12'h200);
    ctrl_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("upd_w", o_w, 48'hFFFF_0004_0005);
    chk("upd_layer", o_wl, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ctrl_en = 0;

    // Write beats update; out-of-range write dropped
    ww_en = 1; ww_l = 2; ww_r = 0; ww_d = 48'hAAAA_AAAA_AAAA;
    wu_en = 1; wu_l = 2; wu_r = 0; wu_d = 48'h0001_0001_0001;
    @(negedge clk);
    idle();
    wr_weight(4, 0, 48'h1234_5678_9ABC);
    wr_code(2, 12'h3F0);
    ctrl_en = 1;
    @(posedge clk); #1;
    chk("wu_w", o_w, 48'hAAAA_AAAA_AAAA);
    @(posedge clk);
    @(negedge clk);
    loc_rst = 1;
    @(negedge clk);
    loc_rst = 0;
    @(posedge clk); #1;
    chk("locrst_layer", o_wl, 32'd0);
    chk("locrst_row", o_wr, 32'd0);
    chk("locrst_w_oor", o_w, 48'd0);
    chk("locrst_dt", o_dt, 4'd1);

    // Pause mid-instruction, then resume at the next row
    @(posedge clk); #1;
    chk("pause_pre_row", o_wr, 32'd1);
    @(negedge clk);
    ctrl_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pause_hold_row", o_wr, 32'd1);
    chk("pause_use_z", uz, 1'b0);
    @(negedge clk);
    ctrl_en = 1;
    @(posedge clk); #1;
    chk("resume_row", o_wr, 32'd2);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_w", o_w, 48'd0);
    chk("arst_row", o_wr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      ww_en = ($urandom_range(0, 3) == 0); ww_l = $urandom_range(0, 4);
      ww_r = $urandom_range(0, 4); ww_d = rnd48();
      wu_en = ($urandom_range(0, 3) == 0); wu_d = rnd48();
      if ($urandom_range(0, 3) == 0) begin
        wu_l = ww_l; wu_r = ww_r;
      end else begin
        wu_l = $urandom_range(0, 4); wu_r = $urandom_range(0, 4);
      end
      xi_en = ($urandom_range(0, 3) == 0); xi_l = $urandom_range(0, 4);
      xi_r = $urandom_range(0, 4); xi_d = rnd48();
      lb_en = ($urandom_range(0, 3) == 0); lb_l = $urandom_range(0, 4);
      lb_r = $urandom_range(0, 4); lb_d = rnd48();
      cw_en = ($urandom_range(0, 2) == 0); cw_line = $urandom_range(0, CD + 5);
      cw_data = 12'($urandom);
      code_en = ($urandom_range(0, 9) != 0);
      ctrl_en = ($urandom_range(0, 5) != 0);
      loc_rst = ($urandom_range(0, 39) == 0);
      if (it == 1500) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
